// File: rtl/lsu_mem_sequencer_pkg.sv
// Shared definitions for the LSU memory sequencer: load/store size codes, FSM states and size decode.
package lsu_mem_sequencer_pkg;

    localparam logic [2:0] SEL_B  = 3'b000;
    localparam logic [2:0] SEL_H  = 3'b001;
    localparam logic [2:0] SEL_W  = 3'b010;
    localparam logic [2:0] SEL_BU = 3'b011;
    localparam logic [2:0] SEL_HU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Unused select codes 101..111 behave as full-word accesses.
    function automatic size_t access_size(input logic [2:0] sel);
        case (sel)
            SEL_B, SEL_BU: return SZ_BYTE;
            SEL_H, SEL_HU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_sequencer_if.sv
// Core-request, response and data-memory signals of the LSU sequencer, bundled with both-side modports.
interface lsu_mem_sequencer_if;

    // Core side: a request transfers on a cycle with req_valid && req_ready; the core holds
    // req_valid and its fields until then. Response is a single-cycle rsp_valid pulse with no
    // backpressure. Memory side: mem_req and all mem_* fields hold until the cycle mem_ack is 1.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_sel;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_sel, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_sel, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_mem_sequencer_lane_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension, store byte enables and lane replication.
module lsu_mem_sequencer_lane_align
    import lsu_mem_sequencer_pkg::*;
(
    input  logic [2:0]  i_ld_sel,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_raw,
    output logic [31:0] o_ld_data,
    input  logic        i_st_we,
    input  logic [2:0]  i_st_sel,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = i_ld_raw[{i_ld_off, 3'b000} +: 8];
        w_half    = i_ld_off[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
        o_ld_data = i_ld_raw;
        case (i_ld_sel)
            SEL_B:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            SEL_H:   o_ld_data = {{16{w_half[15]}}, w_half};
            SEL_BU:  o_ld_data = {24'd0, w_byte};
            SEL_HU:  o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_ld_raw;
        endcase
    end

    // Loads always read the whole word; the lane is picked when the data returns.
    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
        if (i_st_we) begin
            case (access_size(i_st_sel))
                SZ_BYTE: begin
                    o_st_be    = 4'b0001 << i_st_off;
                    o_st_wdata = {4{i_st_data[7:0]}};
                end
                SZ_HALF: begin
                    o_st_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
                    o_st_wdata = {2{i_st_data[15:0]}};
                end
                default: begin
                    o_st_be    = 4'b1111;
                    o_st_wdata = i_st_data;
                end
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// LSU memory sequencer: one core load/store at a time onto a req/ack data-memory port with timeout.
// Optional `LSU_MISALIGN_TRAP_EN: misaligned half/word accesses respond with an error and skip memory.
module lsu_mem_sequencer
    import lsu_mem_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] RESET_PC_DC = 32'd0
) (
    input  logic   clk,
    input  logic   reset,
    lsu_mem_sequencer_if.slave bus,
    output state_t o_dbg_state
);

    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYC - 1);

    state_t      r_state, w_next;
    logic        r_we;
    logic [2:0]  r_sel;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_cnt;
    logic        w_misalign;
    logic        w_timeout;
    logic [31:0] w_ld_data;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((access_size(bus.req_sel) == SZ_HALF) && bus.req_addr[0]) ||
                        ((access_size(bus.req_sel) == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // The last allowed wait cycle is counter == limit-1, so mem_req stays up TIMEOUT_CYC cycles.
    assign w_timeout = (r_cnt == LP_LIMIT);

    lsu_mem_sequencer_lane_align u_lane (
        .i_ld_sel   (r_sel),
        .i_ld_off   (r_off),
        .i_ld_raw   (bus.mem_rdata),
        .o_ld_data  (w_ld_data),
        .i_st_we    (bus.req_we),
        .i_st_sel   (bus.req_sel),
        .i_st_off   (bus.req_addr[1:0]),
        .i_st_data  (bus.req_wdata),
        .o_st_be    (w_st_be),
        .o_st_wdata (w_st_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.req_valid) w_next = w_misalign ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (bus.mem_ack || w_timeout) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_sel   <= SEL_W;
            r_off   <= 2'b00;
            r_addr  <= RESET_PC_DC;
            r_be    <= 4'b0000;
            r_wdata <= RESET_PC_DC;
            r_rdata <= RESET_PC_DC;
            r_err   <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    r_err <= 1'b0;
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_sel   <= bus.req_sel;
                        r_off   <= bus.req_addr[1:0];
                        r_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_be    <= w_st_be;
                        r_wdata <= w_st_wdata;
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_ack) begin
                        r_rdata <= r_we ? 32'd0 : w_ld_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.mem_req   = (r_state == ST_ISSUE);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_be    = r_be;
    assign bus.mem_wdata = r_wdata;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench for lsu_mem_sequencer: directed cases then randomized loads/stores against a byte-lane model.
module tb_lsu_mem_sequencer;
    import lsu_mem_sequencer_pkg::*;

    localparam int TO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   reset;
    state_t dbg_state;
    int     checks = 0;
    int     failures = 0;
    int     rsp_seen = 0;
    int     rsp_expected = 0;
    logic [31:0] exp_q[$];

    lsu_mem_sequencer_if bus();

    lsu_mem_sequencer #(.TIMEOUT_CYC(TO), .RESET_PC_DC(32'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.rsp_valid === 1'b1) rsp_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int model_size(input logic [2:0] sel);
        if (sel == 3'd0 || sel == 3'd3) return 1;
        if (sel == 3'd1 || sel == 3'd4) return 2;
        return 4;
    endfunction

    function automatic int model_lane(input logic [2:0] sel, input logic [31:0] addr);
        int sz;
        sz = model_size(sel);
        return (int'(addr[1:0]) / sz) * sz;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sel, input logic [31:0] addr,
                                               input logic [31:0] raw);
        logic [31:0] v;
        v = raw >> (8 * model_lane(sel, addr));
        if (model_size(sel) == 1) begin
            v = v & 32'hFF;
            if (sel == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (model_size(sel) == 2) begin
            v = v & 32'hFFFF;
            if (sel == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] sel, input logic [31:0] addr);
        if (!we || model_size(sel) == 4) return 4'hF;
        if (model_size(sel) == 1) return 4'(1 << model_lane(sel, addr));
        return 4'(3 << model_lane(sel, addr));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] sel, input logic [31:0] d);
        if (model_size(sel) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (model_size(sel) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] sel, input logic [31:0] addr);
        return (int'(addr[1:0]) % model_size(sel)) != 0;
    endfunction

    // ---------------- scoreboard compare ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    // ack_dly = cycles mem_req is seen without ack; ack_dly >= TO means memory never answers.
    task automatic do_txn(input string tag, input logic we, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_dly, input logic [31:0] raw);
        bit          mis;
        bit          exp_err;
        int          n_wait;
        logic [31:0] exp_rd;
        mis     = TRAP_EN && model_misaligned(sel, addr);
        n_wait  = (ack_dly < TO) ? ack_dly : TO;
        exp_err = mis || (ack_dly >= TO);
        exp_rd  = (we || exp_err) ? 32'd0 : model_load(sel, addr, raw);
        exp_q.push_back(exp_rd);

        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_sel   = sel;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_sel   = 3'($urandom_range(0, 7));

        if (!mis) begin
            check({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
            check({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            check({tag, ".mem_be"}, 32'(bus.mem_be), 32'(model_be(we, sel, addr)));
            check({tag, ".mem_we"}, 32'(bus.mem_we), 32'(we));
            if (we) check({tag, ".mem_wdata"}, bus.mem_wdata, model_wdata(sel, wdata));
            for (int i = 0; i < n_wait; i++) begin
                check({tag, ".mem_req_hold"}, 32'(bus.mem_req), 32'd1);
                bus.mem_rdata = $urandom;
                @(negedge clk);
            end
            if (ack_dly < TO) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = raw;
                @(negedge clk);
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end
        end

        rsp_expected++;
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_q.pop_front());
        check({tag, ".resp_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, ".resp_ready"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check({tag, ".rsp_done"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        we;
        logic [2:0]  sel;
        logic [31:0] addr;
        int          dly;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_sel   = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check("rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst.mem_req", 32'(bus.mem_req), 32'd0);
        check("rst.mem_we", 32'(bus.mem_we), 32'd0);
        check("rst.mem_be", 32'(bus.mem_be), 32'd0);
        check("rst.mem_addr", bus.mem_addr, 32'd0);
        check("rst.mem_wdata", bus.mem_wdata, 32'd0);
        check("rst.state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Stray ack while idle must not start anything.
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("idle_ack.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("idle_ack.req_ready", 32'(bus.req_ready), 32'd1);

        do_txn("lb_0x103", 1'b0, SEL_B, 32'h0000_0103, 32'd0, 0, 32'h8000_0000);
        do_txn("lhu_0x102", 1'b0, SEL_HU, 32'h0000_0102, 32'd0, 3, 32'hBEEF_1234);
        do_txn("sb_0x201", 1'b1, SEL_B, 32'h0000_0201, 32'h0000_00AB, 1, 32'd0);
        do_txn("sh_0x302", 1'b1, SEL_H, 32'h0000_0302, 32'h1234_5678, 0, 32'd0);
        do_txn("lh_0x100", 1'b0, SEL_H, 32'h0000_0100, 32'd0, 0, 32'h0000_8001);
        do_txn("lw_0x102", 1'b0, SEL_W, 32'h0000_0102, 32'd0, 0, 32'hCAFE_F00D);
        do_txn("ld_timeout", 1'b0, SEL_W, 32'h0000_0400, 32'd0, TO + 4, 32'h1111_1111);
        do_txn("ld_ack_at_limit", 1'b0, SEL_BU, 32'h0000_0501, 32'd0, TO - 1, 32'h0000_F700);
        do_txn("st_timeout", 1'b1, SEL_W, 32'h0000_0600, 32'h5555_AAAA, TO, 32'd0);

        // Reset during ISSUE drops the transaction with no response.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_sel   = SEL_W;
        bus.req_addr  = 32'h0000_0700;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_mid.mem_req_before", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid.mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid.rsp_none", 32'(bus.rsp_valid), 32'd0);

        for (int t = 0; t < 40; t++) begin
            we   = 1'($urandom_range(0, 1));
            sel  = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            addr = $urandom;
            dly  = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
            do_txn("rand", we, sel, addr, $urandom, dly, $urandom);
        end

        check("rsp_pulse_count", 32'(rsp_seen), 32'(rsp_expected));
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
